// File: rtl/serial_paralelo_rx.sv
// Per-lane receive deserializer: bit-level COM hunt, byte-aligned lock
// confirmation, then 32-bit word assembly with a valid flag.
module serial_paralelo_rx #(
  parameter logic [7:0]  COM       = 8'hBC,
  parameter logic [7:0]  IDL       = 8'h7C,
  parameter int unsigned COM_COUNT = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_in,
  output logic [31:0] lane,
  output logic        valid,
  output logic        active
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned COMC_W  = 4;
  localparam logic [COMC_W-1:0] COM_TGT = COMC_W'(COM_COUNT);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LOCKING,
    ST_ACTIVE
  } state_e;

  state_e                state_q, state_d;
  // Only the last 7 received bits are needed to form the byte ending now.
  logic [BYTE_W-2:0]     sr_q, sr_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [COMC_W-1:0]     com_cnt_q, com_cnt_d;
  logic [WORD_W-9:0]     word_q, word_d;
  logic                  dirty_q, dirty_d;
  logic [WORD_W-1:0]     lane_q, lane_d;
  logic                  valid_q, valid_d;
  logic                  active_q, active_d;

  logic [BYTE_W-1:0]     nb;
  logic                  nb_is_com;
  logic                  nb_is_ctrl;
  logic                  byte_end;

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    com_cnt_d  = com_cnt_q;
    word_d     = word_q;
    dirty_d    = dirty_q;
    lane_d     = lane_q;
    valid_d    = valid_q;
    nb         = {sr_q, data_in};
    sr_d       = nb[BYTE_W-2:0];
    nb_is_com  = (nb == COM);
    nb_is_ctrl = nb_is_com || (nb == IDL);
    byte_end   = (bit_cnt_q[2:0] == 3'd7);

    case (state_q)
      ST_HUNT: begin
        if (nb_is_com) begin
          bit_cnt_d = '0;
          com_cnt_d = COMC_W'(1);
          if (COM_COUNT == 1) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_LOCKING;
          end
        end
      end

      ST_LOCKING: begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (byte_end) begin
          bit_cnt_d = '0;
          if (nb_is_com) begin
            com_cnt_d = com_cnt_q + COMC_W'(1);
            if (com_cnt_q + COMC_W'(1) == COM_TGT) begin
              state_d = ST_ACTIVE;
            end
          end else begin
            com_cnt_d = '0;
            state_d   = ST_HUNT;
          end
        end
      end

      ST_ACTIVE: begin
        // Free-running word framing; wraps 31 -> 0 naturally.
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (byte_end) begin
          dirty_d = dirty_q || nb_is_ctrl;
          case (bit_cnt_q[4:3])
            2'd0: word_d[23:16] = nb;
            2'd1: word_d[15:8]  = nb;
            2'd2: word_d[7:0]   = nb;
            default: begin
              if (dirty_q || nb_is_ctrl) begin
                valid_d = 1'b0;
              end else begin
                lane_d  = {word_q, nb};
                valid_d = 1'b1;
              end
              dirty_d = 1'b0;
            end
          endcase
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase

    active_d = (state_d == ST_ACTIVE);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q   <= ST_HUNT;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      word_q    <= '0;
      dirty_q   <= 1'b0;
      lane_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      word_q    <= word_d;
      dirty_q   <= dirty_d;
      lane_q    <= lane_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  assign lane   = lane_q;
  assign valid  = valid_q;
  assign active = active_q;

endmodule
